// File: rtl/fir_out_decimator.sv
// rtl/fir_out_decimator.sv - accumulate-and-dump decimator with round/saturate and output FIFO
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_data, in_valid   signed IN_W-bit sample stream from fir_filter
//   out_data, out_valid FIFO head (first-word-fall-through), FIFO non-empty
//   out_ready           consumer takes the head when out_valid && out_ready
//   sat                 one-cycle pulse: the result produced this edge was clipped
//   overflow            sticky: a result was dropped because the FIFO was full
//   level               current FIFO occupancy

module fir_out_decimator #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IN_W-1:0]                 in_data,
  input  logic                            in_valid,
  output logic [OUT_W-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            sat,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     level
);

  localparam int DW = $clog2(DECIM);
  localparam int AW = IN_W + DW;
  localparam int T  = DW + SHIFT;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  // One spare bit so adding the rounding constant to a full-scale sum cannot wrap.
  localparam logic signed [AW:0] RND  = (AW+1)'(1) << (T-1);
  localparam logic signed [AW:0] MAXV = (AW+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [AW:0] MINV = (AW+1)'(-(1 << (OUT_W-1)));

  logic signed [AW-1:0]   acc;
  logic        [DW-1:0]   phase;
  logic signed [AW:0]     sum_w;
  logic signed [AW:0]     rnd_w;
  logic                   clip_hi;
  logic                   clip_lo;
  logic        [OUT_W-1:0] res;
  logic                   dump;

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign sum_w   = (AW+1)'(acc) + (AW+1)'($signed(in_data));
  // Add half an LSB then arithmetic shift: rounds half toward +inf.
  assign rnd_w   = (sum_w + RND) >>> T;
  assign clip_hi = rnd_w > MAXV;
  assign clip_lo = rnd_w < MINV;
  assign res     = clip_hi ? MAXV[OUT_W-1:0] :
                   clip_lo ? MINV[OUT_W-1:0] : rnd_w[OUT_W-1:0];
  assign dump    = in_valid && (phase == DW'(DECIM-1));

  assign full      = (level == LW'(FIFO_DEPTH));
  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rptr] : '0;
  assign pop       = out_valid && out_ready;
  // When full, a push is only accepted if the head leaves on the same edge;
  // the freed slot is exactly the one wptr points at.
  assign push_ok   = dump && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      phase    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      sat      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sat <= dump && (clip_hi || clip_lo);

      if (in_valid) begin
        if (dump) begin
          acc   <= '0;
          phase <= '0;
        end else begin
          acc   <= sum_w[AW-1:0];
          phase <= phase + DW'(1);
        end
      end

      if (push_ok) begin
        mem[wptr] <= res;
        wptr      <= wptr + PW'(1);
      end
      if (dump && full && !pop) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end

      if (push_ok && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push_ok) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule
